systolic_feeder: RTL and testbench

Input staging stage that sits directly upstream of the N×N systolic PE array. Collects a byte stream from the UART receive path into two N×N operand buffers: matrix A first, then matrix B. It then drives the west edge with A rows and the north edge with B columns, using the diagonal skew the array needs, so that every PE(i,j) accumulates the product term A[i][k]·B[k][j] for all k. It also issues the accumulator clear before each pass and a completion pulse after the last operand is fed.

---
 rtl/systolic_feeder.sv | 187 ++++++++++++++++++
 tb/tb_systolic_feeder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// systolic_feeder: stages a row-major byte stream into two N x N operand
// buffers (A then B), then drives the west/north edges of an N x N systolic
// array with diagonally skewed A rows and B columns. Emits a one-cycle
// accumulator clear before each feed and a one-cycle done pulse after it.
module systolic_feeder #(
  parameter int N         = 2,
  parameter int REG_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [REG_WIDTH-1:0]     in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [N*REG_WIDTH-1:0]   a_edge,
  output logic [N*REG_WIDTH-1:0]   b_edge,
  output logic                     array_clr,
  output logic                     feed_valid,
  output logic                     busy,
  output logic                     done
);

  localparam int LW = $clog2(2 * N * N);
  localparam int FW = $clog2(3 * N);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [LW-1:0] LAST_A   = LW'(N * N - 1);
  localparam logic [LW-1:0] LAST_B   = LW'(2 * N * N - 1);
  localparam logic [FW-1:0] LAST_T   = FW'(3 * N - 3);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [2:0] {
    S_LOAD_A,
    S_LOAD_B,
    S_CLEAR,
    S_FEED,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [LW-1:0]        load_cnt_q, load_cnt_d;
  logic [FW-1:0]        feed_cnt_q, feed_cnt_d;
  logic [IW-1:0]        row_q, row_d;
  logic [IW-1:0]        col_q, col_d;

  logic                 in_ready_q, in_ready_d;
  logic                 array_clr_q, array_clr_d;
  logic                 feed_valid_q, feed_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [N*REG_WIDTH-1:0] a_edge_q, a_edge_d;
  logic [N*REG_WIDTH-1:0] b_edge_q, b_edge_d;

  logic                 accept;

  logic [REG_WIDTH-1:0] a_buf_q [N][N];
  logic [REG_WIDTH-1:0] b_buf_q [N][N];

  // Next-state, counters and next values of every registered output.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d      = state_q;
    load_cnt_d   = load_cnt_q;
    feed_cnt_d   = feed_cnt_q;
    row_d        = row_q;
    col_d        = col_q;
    accept       = in_valid & in_ready_q;

    unique case (state_q)
      S_LOAD_A: begin
        if (accept) begin
          load_cnt_d = load_cnt_q + 1'b1;
          if (load_cnt_q == LAST_A) state_d = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        if (accept) begin
          // Counter parks at its final value; it clears only on re-entry to LOAD_A.
          if (load_cnt_q == LAST_B) state_d = S_CLEAR;
          else                      load_cnt_d = load_cnt_q + 1'b1;
        end
      end
      S_CLEAR: begin
        state_d    = S_FEED;
        feed_cnt_d = '0;
      end
      S_FEED: begin
        if (feed_cnt_q == LAST_T) state_d = S_DONE;
        else                      feed_cnt_d = feed_cnt_q + 1'b1;
      end
      S_DONE: begin
        state_d    = S_LOAD_A;
        load_cnt_d = '0;
        feed_cnt_d = '0;
      end
      default: state_d = S_LOAD_A;
    endcase

    // Row-major write pointer; wraps to (0,0) between A and B and after a pass.
    if (accept) begin
      if (col_q == LAST_IDX) begin
        col_d = '0;
        row_d = (row_q == LAST_IDX) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
    if (state_q == S_DONE) begin
      row_d = '0;
      col_d = '0;
    end

    // Outputs are decoded from the next state so they appear registered
    // in the same cycle the FSM occupies that state.
    in_ready_d   = (state_d == S_LOAD_A) || (state_d == S_LOAD_B);
    array_clr_d  = (state_d == S_CLEAR);
    feed_valid_d = (state_d == S_FEED);
    busy_d       = (state_d == S_CLEAR) || (state_d == S_FEED) || (state_d == S_DONE);
    done_d       = (state_d == S_DONE);

    // Skew: row i carries A[i][k] and column j carries B[k][j] at step i+k / j+k.
    a_edge_d = '0;
    b_edge_d = '0;
    if (state_d == S_FEED) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          if (int'(feed_cnt_d) == i + k) begin
            a_edge_d[i*REG_WIDTH +: REG_WIDTH] = a_buf_q[i][k];
            b_edge_d[i*REG_WIDTH +: REG_WIDTH] = b_buf_q[k][i];
          end
        end
      end
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples
    // pre-edge values regardless of statement order.
    if (!reset) begin
      state_q      <= S_LOAD_A;
      load_cnt_q   <= '0;
      feed_cnt_q   <= '0;
      row_q        <= '0;
      col_q        <= '0;
      in_ready_q   <= 1'b1;
      array_clr_q  <= 1'b0;
      feed_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      a_edge_q     <= '0;
      b_edge_q     <= '0;
    end else begin
      state_q      <= state_d;
      load_cnt_q   <= load_cnt_d;
      feed_cnt_q   <= feed_cnt_d;
      row_q        <= row_d;
      col_q        <= col_d;
      in_ready_q   <= in_ready_d;
      array_clr_q  <= array_clr_d;
      feed_valid_q <= feed_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      a_edge_q     <= a_edge_d;
      b_edge_q     <= b_edge_d;
    end
  end

  // Operand buffers: written on each accepted byte, A during LOAD_A, B during LOAD_B.
  always_ff @(posedge clk) begin
    // NOTE: buffers carry no reset; a pass always overwrites every entry before
    // it is read, so resetting them would only cost reset routing.
    if (accept) begin
      if (state_q == S_LOAD_A) a_buf_q[row_q][col_q] <= in_data;
      else                     b_buf_q[row_q][col_q] <= in_data;
    end
  end

  assign in_ready   = in_ready_q;
  assign array_clr  = array_clr_q;
  assign feed_valid = feed_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign a_edge     = a_edge_q;
  assign b_edge     = b_edge_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder with N=2, REG_WIDTH=8.
// Matrices are packed 32-bit words: element (r,c) is byte r*2+c.
module tb_systolic_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_edge;
  logic [15:0] b_edge;
  logic        array_clr;
  logic        feed_valid;
  logic        busy;
  logic        done;

  int compared   = 0;
  int mismatched = 0;
  int acc_cnt    = 0;

  logic [15:0] a_hist [4];
  logic [15:0] b_hist [4];

  // Hand-derived edge vectors for A=[[1,2],[3,4]], B=[[5,6],[7,8]].
  logic [15:0] hand_a [4] = '{16'h0001, 16'h0302, 16'h0400, 16'h0000};
  logic [15:0] hand_b [4] = '{16'h0005, 16'h0607, 16'h0800, 16'h0000};
  int          hand_c [4] = '{19, 22, 43, 50};

  systolic_feeder #(.N(2), .REG_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_edge     (a_edge),
    .b_edge     (b_edge),
    .array_clr  (array_clr),
    .feed_valid (feed_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Count accepted bytes independently of the DUT's internal counter.
  always @(posedge clk) begin
    if (reset && in_valid && in_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] el(input logic [31:0] m, input int r, input int c);
    return m[(r*2+c)*8 +: 8];
  endfunction

  function automatic logic [15:0] exp_a(input logic [31:0] am, input int t);
    logic [15:0] r = '0;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 2; k++)
        if (i + k == t) r[i*8 +: 8] = el(am, i, k);
    return r;
  endfunction

  function automatic logic [15:0] exp_b(input logic [31:0] bm, input int t);
    logic [15:0] r = '0;
    for (int j = 0; j < 2; j++)
      for (int k = 0; k < 2; k++)
        if (k + j == t) r[j*8 +: 8] = el(bm, k, j);
    return r;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"},   in_ready,   1);
    check({tag, "_a_edge"},     a_edge,     0);
    check({tag, "_b_edge"},     b_edge,     0);
    check({tag, "_array_clr"},  array_clr,  0);
    check({tag, "_feed_valid"}, feed_valid, 0);
    check({tag, "_busy"},       busy,       0);
    check({tag, "_done"},       done,       0);
  endtask

  // Streams 8 bytes (A then B); optional random idle gaps. Returns in the CLEAR cycle.
  task automatic load(input logic [31:0] am, input logic [31:0] bm,
                      input bit gappy, input bit hold_after);
    for (int n = 0; n < 8; n++) begin
      if (gappy) begin
        int gap = $urandom_range(0, 2);
        repeat (gap) begin
          in_valid = 1'b0;
          in_data  = 8'($urandom);
          check("gap_ready", in_ready, 1);
          step();
        end
      end
      in_valid = 1'b1;
      in_data  = (n < 4) ? am[n*8 +: 8] : bm[(n-4)*8 +: 8];
      check("load_ready", in_ready, 1);
      check("load_edges", {a_edge, b_edge}, 0);
      step();
    end
    in_valid = hold_after;
    in_data  = 8'hAA;
  endtask

  // Checks CLEAR, four feed steps, DONE, and the return to LOAD_A.
  task automatic check_pass(input logic [31:0] am, input logic [31:0] bm, input bit hand);
    check("clr_pulse", array_clr, 1);
    check("clr_busy",  busy,      1);
    check("clr_ready", in_ready,  0);
    check("clr_fv",    feed_valid, 0);
    check("clr_done",  done,      0);
    check("clr_edges", {a_edge, b_edge}, 0);
    step();
    for (int t = 0; t < 4; t++) begin
      a_hist[t] = a_edge;
      b_hist[t] = b_edge;
      check($sformatf("t%0d_fv", t),    feed_valid, 1);
      check($sformatf("t%0d_clr", t),   array_clr,  0);
      check($sformatf("t%0d_ready", t), in_ready,   0);
      check($sformatf("t%0d_done", t),  done,       0);
      check($sformatf("t%0d_a", t),     a_edge, exp_a(am, t));
      check($sformatf("t%0d_b", t),     b_edge, exp_b(bm, t));
      if (hand) begin
        check($sformatf("t%0d_a_hand", t), a_edge, hand_a[t]);
        check($sformatf("t%0d_b_hand", t), b_edge, hand_b[t]);
      end
      step();
    end
    check("done_pulse", done,       1);
    check("done_busy",  busy,       1);
    check("done_fv",    feed_valid, 0);
    check("done_ready", in_ready,   0);
    check("done_edges", {a_edge, b_edge}, 0);
    step();
    check("post_done",  done,     0);
    check("post_busy",  busy,     0);
    check("post_ready", in_ready, 1);
    check("post_edges", {a_edge, b_edge}, 0);
    // PE(i,j) sees row i delayed by j and column j delayed by i.
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        int pe = 0;
        int ref_c = 0;
        for (int t = 0; t < 4; t++) begin
          if (t - j >= 0 && t - i >= 0)
            pe += int'(a_hist[t-j][i*8 +: 8]) * int'(b_hist[t-i][j*8 +: 8]);
        end
        for (int k = 0; k < 2; k++) ref_c += int'(el(am, i, k)) * int'(el(bm, k, j));
        check($sformatf("c%0d%0d", i, j), pe, ref_c);
        if (hand) check($sformatf("c%0d%0d_hand", i, j), pe, hand_c[i*2+j]);
      end
    end
  endtask

  initial begin
    logic [31:0] mat_a, mat_b;
    int acc0;
    mat_a = 32'h04030201;
    mat_b = 32'h08070605;

    // Reset held from time zero, then released.
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_idle("rst_hold");
    @(negedge clk) reset = 1'b1;
    step();
    check_idle("rst_rel");

    // Partial load, then reset mid-load: the partial load must be discarded.
    for (int n = 0; n < 3; n++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h11 * (n + 1));
      step();
    end
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    check_idle("rst_mid_load");
    @(negedge clk) reset = 1'b1;
    step();
    check_idle("rst_after_load");

    // Basic pass.
    load(mat_a, mat_b, 1'b0, 1'b0);
    check_pass(mat_a, mat_b, 1'b1);

    // Gappy input: same feed, exactly 8 bytes consumed.
    acc0 = acc_cnt;
    load(mat_a, mat_b, 1'b1, 1'b0);
    check("gappy_count", acc_cnt - acc0, 8);
    check_pass(mat_a, mat_b, 1'b1);

    // Backpressure: in_valid held through CLEAR/FEED/DONE consumes nothing.
    load(mat_a, mat_b, 1'b0, 1'b1);
    acc0 = acc_cnt;
    check_pass(mat_a, mat_b, 1'b0);
    check("bp_no_consume", acc_cnt - acc0, 0);
    load(32'h040302AA, 32'h0D0C0B0A, 1'b0, 1'b0);
    check("bp_count", acc_cnt - acc0, 8);
    check_pass(32'h040302AA, 32'h0D0C0B0A, 1'b0);

    // Reset at feed step t1.
    load(mat_a, mat_b, 1'b0, 1'b0);
    step();
    step();
    check("rf_t1_fv", feed_valid, 1);
    check("rf_t1_a",  a_edge, exp_a(mat_a, 1));
    reset = 1'b0;
    #1;
    check_idle("rst_mid_feed");
    @(negedge clk) reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      check("rf_no_done", done, 0);
      check("rf_no_busy", busy, 0);
    end
    load(32'h0F0E0D0C, 32'h13121110, 1'b0, 1'b0);
    check_pass(32'h0F0E0D0C, 32'h13121110, 1'b0);

    // Back-to-back passes at maximum operand values.
    load(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1);
    check_pass(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    load(32'hFF0201FF, 32'h0403FFFF, 1'b0, 1'b1);
    check_pass(32'hFF0201FF, 32'h0403FFFF, 1'b0);
    in_valid = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
